// File: rtl/arith_pkg.sv
// Definitions shared between the multi-precision sequencer and the 16-bit arithmetic unit it drives.
package arith_pkg;

   localparam logic [3:0] AU_ADD = 4'b0000;
   localparam logic [3:0] AU_SUB = 4'b0001;
   localparam logic [3:0] AU_ADC = 4'b0010;
   localparam logic [3:0] AU_SBB = 4'b0011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Plain add/sub for an unchained first limb, carry/borrow variant everywhere else.
   function automatic logic [3:0] limb_sel(input logic chained, input logic sub);
      logic [3:0] sel_s;
      if (chained) begin
         sel_s = sub ? AU_SBB : AU_ADC;
      end else begin
         sel_s = sub ? AU_SUB : AU_ADD;
      end
      return sel_s;
   endfunction

endpackage

// File: rtl/mp_arith_sequencer.sv
// Multi-precision add/subtract sequencer: walks an external 16-bit arithmetic unit over WORDS limbs,
// least-significant first, chaining carry/borrow and assembling the wide result.
module mp_arith_sequencer
   import arith_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  op_sub,
   input  logic                  cin_en,
   input  logic                  cin,
   input  logic [16*WORDS-1:0]   a_wide,
   input  logic [16*WORDS-1:0]   b_wide,
   output logic                  busy,
   output logic                  done,
   output logic [16*WORDS-1:0]   result,
   output logic                  carry_final,
   output logic                  zero_final,
   output logic [15:0]           au_a,
   output logic [15:0]           au_b,
   output logic [3:0]            au_sel,
   output logic                  au_cin,
   input  logic                  au_cout,
   input  logic [15:0]           au_result,
   input  logic                  au_zero
);

   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int W  = 16 * WORDS;
   localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

   state_e          state_r;
   logic [CW-1:0]   index_r;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic            op_sub_r;
   logic            cin_en_r;
   logic            cin_r;
   logic            carry_r;
   logic            zero_acc_r;
   logic            busy_r;
   logic            done_r;
   logic [W-1:0]    result_r;
   logic            carry_final_r;
   logic            zero_final_r;
   logic [CW+3:0]   limb_base_s;
   logic            first_limb_s;

   assign limb_base_s  = {index_r, 4'b0000};
   assign first_limb_s = (index_r == {CW{1'b0}});

   // Arithmetic unit drive: current limb while running, quiet zeros otherwise.
   always_comb begin
      au_a   = 16'h0000;
      au_b   = 16'h0000;
      au_sel = AU_ADD;
      au_cin = 1'b0;
      if (state_r == RUN) begin
         au_a   = a_r[limb_base_s +: 16];
         au_b   = b_r[limb_base_s +: 16];
         au_sel = limb_sel(!(first_limb_s && !cin_en_r), op_sub_r);
         if (first_limb_s) begin
            au_cin = cin_en_r & cin_r;
         end else begin
            au_cin = carry_r;
         end
      end else begin
         au_a   = 16'h0000;
         au_b   = 16'h0000;
         au_sel = AU_ADD;
         au_cin = 1'b0;
      end
   end

   // Sequencer state, operand latch and per-limb result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         index_r       <= {CW{1'b0}};
         a_r           <= {W{1'b0}};
         b_r           <= {W{1'b0}};
         op_sub_r      <= 1'b0;
         cin_en_r      <= 1'b0;
         cin_r         <= 1'b0;
         carry_r       <= 1'b0;
         zero_acc_r    <= 1'b1;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         result_r      <= {W{1'b0}};
         carry_final_r <= 1'b0;
         zero_final_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r        <= a_wide;
                  b_r        <= b_wide;
                  op_sub_r   <= op_sub;
                  cin_en_r   <= cin_en;
                  cin_r      <= cin;
                  index_r    <= {CW{1'b0}};
                  carry_r    <= 1'b0;
                  zero_acc_r <= 1'b1;
                  busy_r     <= 1'b1;
                  state_r    <= RUN;
               end
            end
            RUN: begin
               result_r[limb_base_s +: 16] <= au_result;
               carry_r    <= au_cout;
               zero_acc_r <= zero_acc_r & au_zero;
               if (index_r == LAST_IDX) begin
                  carry_final_r <= au_cout;
                  zero_final_r  <= zero_acc_r & au_zero;
                  busy_r        <= 1'b0;
                  done_r        <= 1'b1;
                  state_r       <= DONE;
               end else begin
                  index_r <= index_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign result      = result_r;
   assign carry_final = carry_final_r;
   assign zero_final  = zero_final_r;

endmodule
